// File: rtl/hook_ctrl_if.sv
// Hook controller bus: swinger/draw-side inputs and hook state outputs.
interface hook_ctrl_if;
    logic        tick;
    logic        fire;
    logic [10:0] swing_x;
    logic [9:0]  swing_y;
    logic        hit;
    logic [7:0]  hit_value;
    logic [1:0]  hit_weight;
    logic        swing_en;
    logic [10:0] hook_x;
    logic [9:0]  hook_y;
    logic [1:0]  state;
    logic        grabbed;
    logic        grab_ack;
    logic        score_valid;
    logic [7:0]  score_value;

    modport master (
        output tick, fire, swing_x, swing_y, hit, hit_value, hit_weight,
        input  swing_en, hook_x, hook_y, state, grabbed, grab_ack, score_valid, score_value
    );

    modport slave (
        input  tick, fire, swing_x, swing_y, hit, hit_value, hit_weight,
        output swing_en, hook_x, hook_y, state, grabbed, grab_ack, score_valid, score_value
    );
endinterface

// File: rtl/hook_ctrl.sv
// Gold Miner hook sequencer: swing, extend along the launch direction, grab, retract, score.
// Hook length n is Q6.6 in swing radii; tip = pivot + (dir * n) >>> 6.
module hook_ctrl #(
    parameter int CENTER_X = 625,
    parameter int CENTER_Y = 11,
    parameter int X_MIN    = 10,
    parameter int X_MAX    = 1269,
    parameter int Y_MAX    = 789,
    parameter int EXT_STEP = 8,
    parameter int RET_STEP = 8,
    parameter int N_MAX    = 768
) (
    input logic        clk,
    input logic        rst,
    hook_ctrl_if.slave hk
);
    typedef enum logic [1:0] {
        StSwing   = 2'd0,
        StExtend  = 2'd1,
        StRetract = 2'd2,
        StScore   = 2'd3
    } state_e;

    localparam logic [9:0]         NHome   = 10'd64;
    localparam logic [9:0]         NMax    = 10'(N_MAX);
    localparam logic [9:0]         ExtStep = 10'(EXT_STEP);
    localparam logic [9:0]         RetStep = 10'(RET_STEP);
    localparam logic [10:0]        CxU     = 11'(CENTER_X);
    localparam logic [9:0]         CyU     = 10'(CENTER_Y);
    localparam logic signed [19:0] CxS     = 20'(CENTER_X);
    localparam logic signed [19:0] CyS     = 20'(CENTER_Y);
    localparam logic signed [19:0] XMinS   = 20'(X_MIN);
    localparam logic signed [19:0] XMaxS   = 20'(X_MAX);
    localparam logic signed [19:0] YMaxS   = 20'(Y_MAX);

    state_e             state_q;
    logic               fire_prev_q, fire_pend_q;
    logic               swing_en_q, grabbed_q, grab_ack_q, score_valid_q;
    logic [7:0]         score_value_q, value_q;
    logic [1:0]         weight_q;
    logic signed [7:0]  dir_x_q, dir_y_q;
    logic [9:0]         n_q;
    logic [10:0]        hook_x_q, home_x_q;
    logic [9:0]         hook_y_q, home_y_q;

    logic               fire_rise;
    logic [1:0]         w_eff;
    logic [9:0]         rs, n_ext, n_ret, n_sel;
    logic signed [19:0] prod_x, prod_y, pos_x, pos_y;
    logic               ext_oob, at_home;

    assign fire_rise = hk.fire & ~fire_prev_q;

    // One shared multiplier pair: extend looks ahead at n+step, retract at n-rs.
    always_comb begin
        w_eff = grabbed_q ? weight_q : 2'd0;
        rs    = RetStep >> w_eff;
        if (rs == '0) rs = 10'd1;
        n_ext   = n_q + ExtStep;
        n_ret   = n_q - rs;
        n_sel   = (state_q == StExtend) ? n_ext : n_ret;
        prod_x  = $signed({{12{dir_x_q[7]}}, dir_x_q}) * $signed({10'd0, n_sel});
        prod_y  = $signed({{12{dir_y_q[7]}}, dir_y_q}) * $signed({10'd0, n_sel});
        pos_x   = CxS + (prod_x >>> 6);
        pos_y   = CyS + (prod_y >>> 6);
        ext_oob = (n_ext > NMax) || (pos_x < XMinS) || (pos_x > XMaxS) || (pos_y > YMaxS);
        at_home = (n_q <= NHome + rs);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StSwing;
            fire_prev_q   <= 1'b0;
            fire_pend_q   <= 1'b0;
            swing_en_q    <= 1'b1;
            grabbed_q     <= 1'b0;
            grab_ack_q    <= 1'b0;
            score_valid_q <= 1'b0;
            score_value_q <= 8'd0;
            value_q       <= 8'd0;
            weight_q      <= 2'd0;
            dir_x_q       <= 8'sd0;
            dir_y_q       <= 8'sd0;
            n_q           <= NHome;
            hook_x_q      <= CxU;
            hook_y_q      <= CyU;
            home_x_q      <= CxU;
            home_y_q      <= CyU;
        end else begin
            fire_prev_q   <= hk.fire;
            grab_ack_q    <= 1'b0;
            score_valid_q <= 1'b0;
            unique case (state_q)
                StSwing: begin
                    hook_x_q <= hk.swing_x;
                    hook_y_q <= hk.swing_y;
                    if (fire_rise) fire_pend_q <= 1'b1;
                    if (hk.tick && fire_pend_q) begin
                        dir_x_q     <= 8'(hk.swing_x - CxU);
                        dir_y_q     <= 8'(hk.swing_y - CyU);
                        home_x_q    <= hk.swing_x;
                        home_y_q    <= hk.swing_y;
                        n_q         <= NHome;
                        swing_en_q  <= 1'b0;
                        fire_pend_q <= 1'b0;
                        state_q     <= StExtend;
                    end
                end
                StExtend: begin
                    if (hk.tick) begin
                        if (hk.hit) begin
                            grabbed_q  <= 1'b1;
                            value_q    <= hk.hit_value;
                            weight_q   <= hk.hit_weight;
                            grab_ack_q <= 1'b1;
                            state_q    <= StRetract;
                        end else if (ext_oob) begin
                            state_q <= StRetract;
                        end else begin
                            n_q      <= n_ext;
                            hook_x_q <= pos_x[10:0];
                            hook_y_q <= pos_y[9:0];
                        end
                    end
                end
                StRetract: begin
                    if (hk.tick) begin
                        if (at_home) begin
                            n_q      <= NHome;
                            hook_x_q <= home_x_q;
                            hook_y_q <= home_y_q;
                            if (grabbed_q) begin
                                score_valid_q <= 1'b1;
                                score_value_q <= value_q;
                                state_q       <= StScore;
                            end else begin
                                swing_en_q <= 1'b1;
                                state_q    <= StSwing;
                            end
                        end else begin
                            n_q      <= n_ret;
                            hook_x_q <= pos_x[10:0];
                            hook_y_q <= pos_y[9:0];
                        end
                    end
                end
                StScore: begin
                    grabbed_q  <= 1'b0;
                    swing_en_q <= 1'b1;
                    state_q    <= StSwing;
                end
            endcase
        end
    end

    assign hk.swing_en    = swing_en_q;
    assign hk.hook_x      = hook_x_q;
    assign hk.hook_y      = hook_y_q;
    assign hk.state       = state_q;
    assign hk.grabbed     = grabbed_q;
    assign hk.grab_ack    = grab_ack_q;
    assign hk.score_valid = score_valid_q;
    assign hk.score_value = score_value_q;
endmodule

// File: tb/tb_hook_ctrl.sv
// Directed bench for hook_ctrl: vector table plus multi-cycle launch/grab/reset sequences.
module tb_hook_ctrl;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    hook_ctrl_if hk ();
    hook_ctrl dut (.clk(clk), .rst(rst), .hk(hk));

    int n_vec = 0;
    int n_err = 0;
    int sv_cnt = 0;

    always @(negedge clk) if (hk.score_valid === 1'b1) sv_cnt++;

    typedef struct {
        logic rst, tick, fire;
        int   sx, sy;
        logic hit;
        int   hv, hw;
        int   st, en, hx, hy, gr, ga, sv, sval;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic r, t, f, input int sx, sy, input logic h,
                                input int hv, hw, st, en, hx, hy, gr, ga, sv, sval);
        vec_t v;
        v.rst = r; v.tick = t; v.fire = f; v.sx = sx; v.sy = sy;
        v.hit = h; v.hv = hv; v.hw = hw;
        v.st = st; v.en = en; v.hx = hx; v.hy = hy;
        v.gr = gr; v.ga = ga; v.sv = sv; v.sval = sval;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic clk1();
        @(posedge clk);
        #1;
    endtask

    task automatic tick1();
        hk.tick = 1'b1;
        clk1();
        hk.tick = 1'b0;
    endtask

    task automatic launch(input int sx, input int sy);
        hk.swing_x = 11'(sx);
        hk.swing_y = 10'(sy);
        hk.fire = 1'b1;
        clk1();
        hk.fire = 1'b0;
        tick1();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int steps, ticks, sv0, lx, ly;
        string tag;
        rst = 1'b1;
        hk.tick = 0; hk.fire = 0; hk.swing_x = 11'd625; hk.swing_y = 10'd11;
        hk.hit = 0; hk.hit_value = 8'd0; hk.hit_weight = 2'd0;

        //          rst tk fr  sx   sy  hit hv hw | st en  hx   hy gr ga sv sval
        tbl.push_back(mk(1, 0, 0, 625, 11, 0,  0, 0,  0, 1, 625, 11, 0, 0, 0,  0));
        tbl.push_back(mk(0, 0, 0, 600, 20, 0,  0, 0,  0, 1, 600, 20, 0, 0, 0,  0));
        tbl.push_back(mk(0, 1, 0, 610, 30, 0,  0, 0,  0, 1, 610, 30, 0, 0, 0,  0));
        tbl.push_back(mk(0, 0, 1, 625, 86, 0,  0, 0,  0, 1, 625, 86, 0, 0, 0,  0));
        tbl.push_back(mk(0, 1, 1, 625, 86, 0,  0, 0,  1, 0, 625, 86, 0, 0, 0,  0));
        tbl.push_back(mk(0, 0, 0, 700, 50, 0,  0, 0,  1, 0, 625, 86, 0, 0, 0,  0));
        tbl.push_back(mk(0, 1, 0, 700, 50, 0,  0, 0,  1, 0, 625, 95, 0, 0, 0,  0));
        tbl.push_back(mk(0, 1, 0, 700, 50, 0,  0, 0,  1, 0, 625, 104, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 700, 50, 1, 50, 2,  2, 0, 625, 104, 1, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 700, 50, 0,  0, 0,  2, 0, 625, 104, 1, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 700, 50, 0,  0, 0,  2, 0, 625, 102, 1, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 700, 50, 1, 99, 3,  2, 0, 625, 100, 1, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 700, 50, 0,  0, 0,  2, 0, 625, 97, 1, 0, 0,  0));
        tbl.push_back(mk(0, 1, 0, 700, 50, 0,  0, 0,  2, 0, 625, 95, 1, 0, 0,  0));
        tbl.push_back(mk(0, 1, 0, 700, 50, 0,  0, 0,  2, 0, 625, 93, 1, 0, 0,  0));
        tbl.push_back(mk(0, 1, 0, 700, 50, 0,  0, 0,  2, 0, 625, 90, 1, 0, 0,  0));
        tbl.push_back(mk(0, 1, 0, 700, 50, 0,  0, 0,  2, 0, 625, 88, 1, 0, 0,  0));
        tbl.push_back(mk(0, 1, 0, 700, 50, 0,  0, 0,  3, 0, 625, 86, 1, 0, 1, 50));
        tbl.push_back(mk(0, 0, 0, 700, 50, 0,  0, 0,  0, 1, 625, 86, 0, 0, 0, 50));
        tbl.push_back(mk(0, 0, 0, 700, 50, 0,  0, 0,  0, 1, 700, 50, 0, 0, 0, 50));

        foreach (tbl[i]) begin
            rst = tbl[i].rst; hk.tick = tbl[i].tick; hk.fire = tbl[i].fire;
            hk.swing_x = 11'(tbl[i].sx); hk.swing_y = 10'(tbl[i].sy);
            hk.hit = tbl[i].hit; hk.hit_value = 8'(tbl[i].hv); hk.hit_weight = 2'(tbl[i].hw);
            clk1();
            tag = $sformatf("row%0d", i);
            chk({tag, " state"}, hk.state, tbl[i].st);
            chk({tag, " swing_en"}, hk.swing_en, tbl[i].en);
            chk({tag, " hook_x"}, hk.hook_x, tbl[i].hx);
            chk({tag, " hook_y"}, hk.hook_y, tbl[i].hy);
            chk({tag, " grabbed"}, hk.grabbed, tbl[i].gr);
            chk({tag, " grab_ack"}, hk.grab_ack, tbl[i].ga);
            chk({tag, " score_valid"}, hk.score_valid, tbl[i].sv);
            chk({tag, " score_value"}, hk.score_value, tbl[i].sval);
        end
        hk.tick = 0; hk.fire = 0; hk.hit = 0;

        // Idle tracking: registered with exactly one clock of lag.
        for (int i = 0; i < 10; i++) begin
            lx = 100 + i * 37;
            ly = 20 + i * 5;
            hk.swing_x = 11'(lx); hk.swing_y = 10'(ly);
            #1;
            if (i > 0) chk("track lag x", hk.hook_x, lx - 37);
            tick1();
            chk("track x", hk.hook_x, lx);
            chk("track y", hk.hook_y, ly);
            chk("track state", hk.state, 0);
        end

        // Straight down to the floor with fire held through the whole cycle.
        sv0 = sv_cnt;
        hk.swing_x = 11'd625; hk.swing_y = 10'd86; hk.fire = 1'b1;
        clk1();
        tick1();
        chk("down launch state", hk.state, 1);
        chk("down launch swing_en", hk.swing_en, 0);
        steps = 0;
        for (int i = 0; i < 200 && hk.state == 2'd1; i++) begin
            tick1();
            if (hk.state == 2'd1) steps++;
        end
        chk("down extend steps", steps, 75);
        chk("down stop y", hk.hook_y, 789);
        chk("down retract state", hk.state, 2);
        chk("down no grab", hk.grabbed, 0);
        ticks = 0;
        for (int i = 0; i < 400 && hk.state == 2'd2; i++) begin
            tick1();
            ticks++;
        end
        chk("down retract ticks", ticks, 75);
        chk("down home x", hk.hook_x, 625);
        chk("down home y", hk.hook_y, 86);
        chk("down back swing", hk.state, 0);
        for (int i = 0; i < 5; i++) tick1();
        chk("held fire single launch", hk.state, 0);
        chk("held fire swing_en", hk.swing_en, 1);
        chk("down no score", sv_cnt - sv0, 0);
        hk.fire = 1'b0;
        clk1();

        // Leftward launch, with fire pulses during extend that must not queue.
        launch(550, 11);
        chk("left launch state", hk.state, 1);
        tick1();
        chk("left step1 x", hk.hook_x, 540);
        chk("left step1 y", hk.hook_y, 11);
        tick1();
        chk("left step2 x", hk.hook_x, 531);
        hk.fire = 1'b1; tick1(); hk.fire = 1'b0; tick1();
        steps = 4;
        for (int i = 0; i < 200 && hk.state == 2'd1; i++) begin
            tick1();
            if (hk.state == 2'd1) steps++;
        end
        chk("left extend steps", steps, 57);
        chk("left stop x", hk.hook_x, 15);
        chk("left stop y", hk.hook_y, 11);
        ticks = 0;
        for (int i = 0; i < 400 && hk.state == 2'd2; i++) begin
            tick1();
            ticks++;
        end
        chk("left retract ticks", ticks, 57);
        chk("left home x", hk.hook_x, 550);
        for (int i = 0; i < 5; i++) tick1();
        chk("left no relaunch", hk.state, 0);

        // Hit on the same tick the tip would leave the playfield: grab wins.
        sv0 = sv_cnt;
        launch(625, 86);
        for (int i = 0; i < 75; i++) tick1();
        chk("edge pre state", hk.state, 1);
        chk("edge pre y", hk.hook_y, 789);
        hk.hit = 1'b1; hk.hit_value = 8'd200; hk.hit_weight = 2'd1;
        tick1();
        hk.hit = 1'b0;
        chk("edge grab state", hk.state, 2);
        chk("edge grabbed", hk.grabbed, 1);
        chk("edge grab_ack", hk.grab_ack, 1);
        clk1();
        chk("edge grab_ack pulse", hk.grab_ack, 0);
        ticks = 0;
        for (int i = 0; i < 400 && hk.state == 2'd2; i++) begin
            tick1();
            ticks++;
        end
        chk("edge retract ticks", ticks, 150);
        chk("edge score state", hk.state, 3);
        chk("edge score_valid", hk.score_valid, 1);
        chk("edge score_value", hk.score_value, 200);
        chk("edge home y", hk.hook_y, 86);
        clk1();
        chk("edge after state", hk.state, 0);
        chk("edge after score_valid", hk.score_valid, 0);
        chk("edge after grabbed", hk.grabbed, 0);
        chk("edge after swing_en", hk.swing_en, 1);
        chk("edge score count", sv_cnt - sv0, 1);

        // Reset in mid-retract with an object on the hook.
        sv0 = sv_cnt;
        launch(625, 86);
        for (int i = 0; i < 10; i++) tick1();
        hk.hit = 1'b1; hk.hit_value = 8'd77; hk.hit_weight = 2'd3;
        tick1();
        hk.hit = 1'b0;
        for (int i = 0; i < 3; i++) tick1();
        chk("rst pre state", hk.state, 2);
        chk("rst pre grabbed", hk.grabbed, 1);
        rst = 1'b1;
        clk1();
        rst = 1'b0;
        chk("rst state", hk.state, 0);
        chk("rst swing_en", hk.swing_en, 1);
        chk("rst hook_x", hk.hook_x, 625);
        chk("rst hook_y", hk.hook_y, 11);
        chk("rst grabbed", hk.grabbed, 0);
        chk("rst score_value", hk.score_value, 0);
        hk.swing_x = 11'd640; hk.swing_y = 10'd60;
        for (int i = 0; i < 30; i++) tick1();
        chk("rst no score", sv_cnt - sv0, 0);
        chk("rst idle state", hk.state, 0);
        chk("rst idle track", hk.hook_x, 640);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/hook_ctrl.md
Name: hook_ctrl

Overview:
Sequences the Gold Miner hook through swing, launch, extend, grab and retract. While idle it lets the pendulum swing generator run and mirrors its position. On a centre-button press it freezes the swinger and drives the hook outward along the swing direction, then reels it back at a weight-dependent speed. It emits a one-cycle score event when a grabbed object arrives home. It sits between the swing generator and the draw controller, and runs on the pixel clock with a frame tick enable.

Parameters:
CENTER_X, 625, pivot x (px)
CENTER_Y, 11, pivot y (px)
X_MIN, 10, left playfield bound
X_MAX, 1269, right playfield bound
Y_MAX, 789, bottom playfield bound
EXT_STEP, 8, extension increment of n per tick (Q6.6; 64 = one swing radius)
RET_STEP, 8, base retract increment per tick (Q6.6)
N_MAX, 768, maximum n (12.0 radii)

Ports:
clk  in  1  pixel clock
rst  in  1  synchronous active-high reset
tick  in  1  one-clk frame enable pulse (60 Hz)
fire  in  1  centre button, already synchronised, level
swing_x  in  11  swinger x
swing_y  in  10  swinger y
hit  in  1  hook tip overlaps an object (from draw side)
hit_value  in  8  value of the overlapped object
hit_weight  in  2  weight class of the overlapped object
swing_en  out  1  1 = swinger may advance
hook_x  out  11  hook tip x
hook_y  out  10  hook tip y
state  out  2  0 SWING, 1 EXTEND, 2 RETRACT, 3 SCORE
grabbed  out  1  object currently on hook
grab_ack  out  1  one-clk pulse on grab (object manager removes object)
score_valid  out  1  one-clk pulse on delivery
score_value  out  8  latched hit_value; valid with score_valid

Behaviour:
- Reset: state=SWING, swing_en=1, hook_x=CENTER_X, hook_y=CENTER_Y, n=64, dir=0, grabbed=0, grab_ack=0, score_valid=0, score_value=0, fire_pend=0.
- fire rising edge (registered prev) sets fire_pend, only in SWING. Outside SWING, edges are ignored and never queued. A held fire gives one launch.
- SWING: hook_x/y <= swing_x/y every clk (1-clk latency). On tick with fire_pend:
  - latch dir_x = swing_x - CENTER_X (signed 8b, ±75) and dir_y = swing_y - CENTER_Y (8b, 0..75);
  - n=64, swing_en<=0, fire_pend<=0, go EXTEND.
- Position for EXTEND/RETRACT: off = (dir * n) >>> 6, arithmetic shift on a signed 20b product; hook = CENTER + off, truncated to port width after the bound check.
- EXTEND, on tick, with n' = n + EXT_STEP:
  - hit=1: grabbed<=1, latch value/weight, grab_ack pulse, go RETRACT. No step.
  - else if n' > N_MAX, or pos(n') has x<X_MIN, x>X_MAX or y>Y_MAX: go RETRACT, n unchanged, grabbed=0.
  - else n<=n'.
  - hit takes priority over an out-of-bounds condition on the same tick.
- RETRACT, on tick:
  - rs = RET_STEP >> weight, minimum 1 (weight counts as 0 when not grabbed).
  - If n - rs <= 64: n<=64, hook<=swing position latched at launch. Go SCORE if grabbed, else SWING.
  - Else n<=n-rs.
  - hit is ignored during RETRACT.
- SCORE: one clk. score_valid=1, score_value=latched value, grabbed<=0, swing_en<=1, then SWING.
- swing_en is 0 in EXTEND, RETRACT and SCORE, so the swinger resumes exactly where it froze.
- Non-tick clks hold n, state and hook outputs.
- grab_ack and score_valid are single-clk pulses, 0 otherwise.
- rst mid-operation returns everything to reset values immediately; a pending grab is lost with no score.

Test Plan:
- Reset, then 10 ticks, no fire: state=0, swing_en=1, hook tracks swing_x/y with 1-clk lag.
- Swing at (625,86), fire pulse, tick: EXTEND, swing_en=0. Next tick: n=72, hook=(625,95). Further ticks: hook stops at y=789 (n=664) after 75 steps, then RETRACT with no grab; 75 retract ticks back to (625,86); state=SWING, no score_valid.
- Swing at (550,11), launch, ticks: hook_x decreases ~9.375/tick and hook_y stays 11. Stops before x<10, then retracts.
- Launch straight down, assert hit with value=50, weight=2 on tick 5: grab_ack one clk, grabbed=1, rs=2. Retract takes 4x the extend ticks; one SCORE clk with score_valid=1, score_value=50; then SWING.
- hit and out-of-bounds on the same tick: grab wins. Fire held high across a full cycle: exactly one launch. Fire pulses during EXTEND: no relaunch after return.
- rst asserted mid-RETRACT with grabbed=1: next clk has reset values and no score_valid ever.
